// File: rtl/jk_bank_arbiter.sv
// Round-robin two-port controller for a negedge-clocked JK flip-flop bank.
// Drives masked SET/CLEAR/TOGGLE/READ operations for one cycle and verifies the readback.
module jk_bank_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [1:0]       op_a,
  input  logic [1:0]       op_b,
  input  logic [WIDTH-1:0] mask_a,
  input  logic [WIDTH-1:0] mask_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic             err,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] Q_in,
  output logic             bank_reset,
  output logic             busy
);

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_GRANT  = 3'd2;
  localparam logic [2:0] S_DRIVE  = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [1:0]       init_cnt;
  logic             last_b;
  logic             sel_b;
  logic             pick_b;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] pre_r;

  // Bank encoding: J clears, K sets, both toggle.
  function automatic logic [WIDTH-1:0] drive_j(input logic [1:0] op, input logic [WIDTH-1:0] m);
    return (op == OP_CLEAR || op == OP_TOGGLE) ? m : '0;
  endfunction

  function automatic logic [WIDTH-1:0] drive_k(input logic [1:0] op, input logic [WIDTH-1:0] m);
    return (op == OP_SET || op == OP_TOGGLE) ? m : '0;
  endfunction

  // For TOGGLE, "masked bits flipped and unmasked bits kept" collapses to (q ^ pre) == m.
  function automatic logic check_err(input logic [1:0] op, input logic [WIDTH-1:0] m,
                                     input logic [WIDTH-1:0] pre, input logic [WIDTH-1:0] q);
    case (op)
      OP_SET:    return |(~q & m);
      OP_CLEAR:  return |(q & m);
      OP_TOGGLE: return (q ^ pre) != m;
      default:   return 1'b0;
    endcase
  endfunction

  always_comb begin
    pick_b   = req_b && (!req_a || !last_b);
    sel_op   = sel_b ? op_b : op_a;
    sel_mask = sel_b ? mask_b : mask_a;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:   if (init_cnt == 2'd2) state_nxt = S_IDLE;
      S_IDLE:   if (req_a || req_b) state_nxt = S_GRANT;
      S_GRANT:  state_nxt = (sel_op == OP_READ) ? S_SETTLE : S_DRIVE;
      S_DRIVE:  state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_INIT;
      init_cnt   <= 2'd0;
      last_b     <= 1'b1;
      sel_b      <= 1'b0;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      done_a     <= 1'b0;
      done_b     <= 1'b0;
      err        <= 1'b0;
      rd_data    <= '0;
      J          <= '0;
      K          <= '0;
      bank_reset <= 1'b1;
      busy       <= 1'b1;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != S_IDLE);
      bank_reset <= (state_nxt == S_INIT);
      init_cnt   <= (state == S_INIT) ? init_cnt + 2'd1 : 2'd0;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      done_a     <= 1'b0;
      done_b     <= 1'b0;
      err        <= 1'b0;
      J          <= '0;
      K          <= '0;
      case (state)
        S_IDLE: begin
          if (req_a || req_b) begin
            sel_b <= pick_b;
            gnt_a <= !pick_b;
            gnt_b <= pick_b;
          end
        end
        S_GRANT: begin
          // J/K become visible for the whole DRIVE cycle, covering the bank's negedge.
          if (sel_op != OP_READ) begin
            J <= drive_j(sel_op, sel_mask);
            K <= drive_k(sel_op, sel_mask);
          end
        end
        S_SETTLE: begin
          rd_data <= Q_in;
          err     <= check_err(op_r, mask_r, pre_r, Q_in);
          done_a  <= !sel_b;
          done_b  <= sel_b;
        end
        S_DONE: last_b <= sel_b;
        default: ;
      endcase
    end
  end

  // Operation capture: later requester input changes cannot affect the check.
  always_ff @(posedge Clk) begin
    if (state == S_GRANT) begin
      op_r   <= sel_op;
      mask_r <= sel_mask;
      pre_r  <= Q_in;
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: JK bank model plus a value-level reference model of the
// arbitration order, cycle schedule, bank contents and readback error.
module tb_jk_bank_arbiter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       req_a, req_b;
  logic [1:0] op_a, op_b;
  logic [7:0] mask_a, mask_b;
  logic       gnt_a, gnt_b, done_a, done_b, err;
  logic [7:0] rd_data, J, K;
  logic [7:0] bank_q;
  logic       bank_reset, busy;

  int   checks = 0;
  int   errors = 0;
  logic force0 = 1'b0;
  logic hold_reqs = 1'b0;
  logic scramble = 1'b0;
  logic [7:0] m_bank = 8'h00;
  logic       m_last_b = 1'b1;
  logic [7:0] nq;

  jk_bank_arbiter #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .mask_a(mask_a), .mask_b(mask_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b), .err(err),
    .rd_data(rd_data), .J(J), .K(K), .Q_in(bank_q),
    .bank_reset(bank_reset), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // JK bank: {J,K} 00 hold, 01 set, 10 clear, 11 toggle; optional stuck-at-0 on bit 0.
  always @(negedge Clk) begin
    nq = bank_q;
    if (bank_reset) nq = 8'h00;
    else begin
      for (int i = 0; i < 8; i++) begin
        case ({J[i], K[i]})
          2'b01:   nq[i] = 1'b1;
          2'b10:   nq[i] = 1'b0;
          2'b11:   nq[i] = ~bank_q[i];
          default: nq[i] = bank_q[i];
        endcase
      end
    end
    if (force0) nq[0] = 1'b0;
    bank_q <= nq;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic init_seq();
    for (int i = 1; i <= 3; i++) begin
      step();
      check_eq("init_bank_reset", 32'(bank_reset), 32'(i < 3));
      check_eq("init_busy", 32'(busy), 32'(i < 3));
      check_eq("init_done", 32'({done_a, done_b}), 32'd0);
    end
  endtask

  task automatic run_round(input int abort_at);
    logic       wb, e;
    logic [1:0] op;
    logic [7:0] m, pre, res, ej, ek;
    int         len;
    if (!req_a && !req_b) begin
      step();
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_gnt", 32'({gnt_a, gnt_b}), 32'd0);
      return;
    end
    wb  = req_b && (!req_a || !m_last_b);
    op  = wb ? op_b : op_a;
    m   = wb ? mask_b : mask_a;
    pre = m_bank;
    case (op)
      2'b01:   res = pre | m;
      2'b10:   res = pre & ~m;
      2'b11:   res = pre ^ m;
      default: res = pre;
    endcase
    if (force0) res[0] = 1'b0;
    case (op)
      2'b01:   e = (res & m) != m;
      2'b10:   e = (res & m) != 8'h00;
      2'b11:   e = (((res ^ pre) & m) != m) || (((res ^ pre) & ~m) != 8'h00);
      default: e = 1'b0;
    endcase
    ej  = (op == 2'b10 || op == 2'b11) ? m : 8'h00;
    ek  = (op == 2'b01 || op == 2'b11) ? m : 8'h00;
    len = (op == 2'b00) ? 3 : 4;
    for (int c = 1; c <= len; c++) begin
      step();
      if (c == abort_at) begin
        #2 Reset = 1'b0;
        #1;
        check_eq("abort_j", 32'(J), 32'd0);
        check_eq("abort_k", 32'(K), 32'd0);
        check_eq("abort_gnt", 32'({gnt_a, gnt_b}), 32'd0);
        check_eq("abort_done", 32'({done_a, done_b}), 32'd0);
        check_eq("abort_bank_reset", 32'(bank_reset), 32'd1);
        check_eq("abort_busy", 32'(busy), 32'd1);
        req_a = 1'b0;
        req_b = 1'b0;
        m_bank = 8'h00;
        m_last_b = 1'b1;
        @(negedge Clk) Reset = 1'b1;
        init_seq();
        return;
      end
      check_eq("gnt_a", 32'(gnt_a), 32'(c == 1 && !wb));
      check_eq("gnt_b", 32'(gnt_b), 32'(c == 1 && wb));
      check_eq("done_a", 32'(done_a), 32'(c == len && !wb));
      check_eq("done_b", 32'(done_b), 32'(c == len && wb));
      check_eq("busy", 32'(busy), 32'd1);
      check_eq("j", 32'(J), 32'((c == 2 && op != 2'b00) ? ej : 8'h00));
      check_eq("k", 32'(K), 32'((c == 2 && op != 2'b00) ? ek : 8'h00));
      check_eq("err", 32'(err), 32'(c == len && e));
      if (c == len) check_eq("rd_data", 32'(rd_data), 32'(res));
      if (scramble && c == 2) begin
        if (wb) begin op_b = 2'($urandom); mask_b = 8'($urandom); end
        else begin op_a = 2'($urandom); mask_a = 8'($urandom); end
      end
    end
    m_bank = res;
    m_last_b = wb;
    if (!hold_reqs) begin
      if (wb) req_b = 1'b0;
      else req_a = 1'b0;
    end
    step();
    check_eq("post_busy", 32'(busy), 32'd0);
    check_eq("post_gnt", 32'({gnt_a, gnt_b}), 32'd0);
    check_eq("post_done", 32'({done_a, done_b}), 32'd0);
    check_eq("post_err", 32'(err), 32'd0);
    check_eq("post_rd_hold", 32'(rd_data), 32'(res));
  endtask

  initial begin
    Reset = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    op_a = 2'b00; op_b = 2'b00;
    mask_a = 8'h00; mask_b = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    check_eq("rst_bank_reset", 32'(bank_reset), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_jk", 32'({J, K}), 32'd0);
    check_eq("rst_gnt", 32'({gnt_a, gnt_b}), 32'd0);
    check_eq("rst_done", 32'({done_a, done_b}), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge Clk) Reset = 1'b1;
    init_seq();

    req_a = 1'b1; op_a = 2'b00; mask_a = 8'h3C; run_round(0);
    req_a = 1'b1; op_a = 2'b01; mask_a = 8'hA5; run_round(0);
    req_b = 1'b1; op_b = 2'b11; mask_b = 8'h0F; run_round(0);
    req_b = 1'b1; op_b = 2'b10; mask_b = 8'hF0; run_round(0);

    hold_reqs = 1'b1;
    req_a = 1'b1; op_a = 2'b11; mask_a = 8'hFF;
    req_b = 1'b1; op_b = 2'b00; mask_b = 8'h00;
    repeat (4) run_round(0);
    hold_reqs = 1'b0;
    req_a = 1'b0; req_b = 1'b0;

    force0 = 1'b1;
    req_a = 1'b1; op_a = 2'b01; mask_a = 8'h01; run_round(0);
    force0 = 1'b0;

    req_a = 1'b1; op_a = 2'b11; mask_a = 8'h00; run_round(0);
    req_b = 1'b1; op_b = 2'b01; mask_b = 8'hFF; run_round(2);
    req_a = 1'b1; op_a = 2'b00; mask_a = 8'h00; run_round(0);

    scramble = 1'b1;
    repeat (200) begin
      if (!req_a && $urandom_range(1, 0) == 1) begin
        req_a = 1'b1; op_a = 2'($urandom); mask_a = 8'($urandom);
        if ($urandom_range(7, 0) == 0) mask_a = 8'h00;
      end
      if (!req_b && $urandom_range(1, 0) == 1) begin
        req_b = 1'b1; op_b = 2'($urandom); mask_b = 8'($urandom);
        if ($urandom_range(7, 0) == 0) mask_b = 8'h00;
      end
      run_round(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Controller and two-port arbiter for a WIDTH-bit bank of negedge-clocked JK flip-flops. Two requesters issue masked SET/CLEAR/TOGGLE/READ operations. The block arbitrates between them round-robin, drives the bank's J/K vectors for exactly one cycle, reads back the result and checks it. It also sequences the bank's synchronous reset after power-up.

## Interface
- WIDTH, 8, number of JK flip-flops in the bank
- Clk  in  1  system clock; block logic on posedge, bank captures on negedge
- Reset  in  1  asynchronous, active-low block reset
- req_a / req_b  in  1  request; held until done_x
- op_a / op_b  in  2  00 READ, 01 SET, 10 CLEAR, 11 TOGGLE; held with req
- mask_a / mask_b  in  WIDTH  bits affected; held with req; ignored for READ
- gnt_a / gnt_b  out  1  one-cycle pulse, request accepted
- done_a / done_b  out  1  one-cycle pulse, operation complete
- err  out  1  valid with done: readback mismatch
- rd_data  out  WIDTH  bank Q sampled at completion; held until next done
- J, K  out  WIDTH each  to bank
- Q_in  in  WIDTH  bank Q outputs
- bank_reset  out  1  to bank's active-high synchronous Reset
- busy  out  1  high in every state except IDLE

## Operation
- Bank encoding per bit {J,K}: 00 hold, 01 Q←1, 10 Q←0, 11 toggle.
- Drive per op for masked bits m:
  - SET: J=0, K=m
  - CLEAR: J=m, K=0
  - TOGGLE: J=m, K=m
  - READ: no drive
- Unmasked bits and all non-DRIVE states: J=K=0.
- FSM states: INIT, IDLE, GRANT, DRIVE, SETTLE, DONE.
- INIT: bank_reset=1. Leave after 2 full cycles following Reset deassertion, then go to IDLE.
- IDLE: sample req_a/req_b at posedge. Neither high → stay. One high → GRANT for it. Both high → grant the requester not granted last.
- last_grant resets to B, so A wins the first tie.
- GRANT: gnt_x=1. Latch op, mask, requester id, and pre=Q_in. READ → SETTLE. Otherwise → DRIVE.
- DRIVE: J/K driven from the latched op/mask. The bank updates on the negedge inside this cycle. → SETTLE.
- SETTLE: J=K=0. At the closing posedge, rd_data←Q_in and err is computed:
  - SET: err if any masked bit of Q_in is 0
  - CLEAR: err if any masked bit of Q_in is 1
  - TOGGLE: err if (Q_in^pre)&mask ≠ mask, or if (Q_in^pre)&~mask ≠ 0
  - READ: err=0
  - → DONE
- DONE: done_x=1 and err valid for this one cycle. last_grant←x. → IDLE.
- err is 0 outside DONE.
- Requester inputs are latched in GRANT, so input changes after GRANT have no effect.
- Deasserting req after GRANT does not abort the operation; done still pulses.
- req still high at the posedge ending the first IDLE cycle after DONE is a new request.
- mask=0 with SET/CLEAR/TOGGLE runs the full sequence with J=K=0 and gives err=0.
- Reset asserted in any state: all outputs go to reset values immediately and the FSM goes to INIT. A half-driven operation is abandoned; the bank is re-cleared by INIT.

## Timing
- Reset values: bank_reset=1, busy=1, J=K=0, gnt_a=gnt_b=0, done_a=done_b=0, err=0, rd_data=0, FSM=INIT.
- After Reset rises, the first IDLE cycle is the 3rd cycle.
- Request sampled at IDLE edge E0 (cycles counted from E0):
  - gnt in cycle 1
  - DRIVE in cycle 2 (SET/CLEAR/TOGGLE only)
  - done in cycle 4 for SET/CLEAR/TOGGLE, cycle 3 for READ
- Throughput: one op per 5 cycles (4 for READ), counting the IDLE cycle.
- All outputs are registered.
- J/K are stable from posedge to posedge, so the bank's negedge sample sees a half-cycle setup.

## Test plan
- Reset release, then READ from A (bank cleared): bank_reset high for 2 cycles after release, gnt_a in cycle 1, done_a in cycle 3, rd_data=8'h00, err=0.
- SET from A, mask=8'hA5, from zero bank: J=8'h00, K=8'hA5 during DRIVE only, done_a at cycle 4, rd_data=8'hA5, err=0.
- TOGGLE from B, mask=8'h0F, bank=8'hA5: rd_data=8'hAA, err=0. Then CLEAR, mask=8'hF0: rd_data=8'h0A.
- req_a and req_b high together, held continuously: grants alternate A, B, A, B. Exactly one done per grant, none overlapping.
- Bank model forced to hold bit 0 at 0 during SET, mask=8'h01: err=1 coincident with done, rd_data[0]=0.
- Reset pulled low during DRIVE: J=K=0, gnt/done low immediately. After release, INIT re-runs and no done is issued for the aborted op.
